// File: rtl/s420_drv.sv
// s420_drv: drives the s420 compare word and count enable for a programmed run length.
// Define S420_DRV_HITCNT_EN to build the Z sampling and saturating hit counter.
module s420_drv #(
  parameter int CW = 17,
  parameter int RW = 16,
  parameter int HW = 16
) (
  input  logic          CK,
  input  logic          RN,
  input  logic          cfg_valid,
  output logic          cfg_ready,
  input  logic [CW-1:0] cfg_data,
  input  logic          start,
  input  logic          stop,
  input  logic [RW-1:0] run_len,
  output logic [CW-1:0] C,
  output logic          P_0,
  input  logic          Z,
  output logic          busy,
  output logic          done,
  output logic [HW-1:0] hit_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  localparam logic [RW-1:0] CNT_ONE = RW'(1);

  state_e        state_q, state_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] c_q, c_d;
  logic [CW-1:0] shadow_q, shadow_d;
  logic          pending_q, pending_d;
  logic          p0_q, p0_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          cfg_accept_s;

  assign cfg_ready    = ~pending_q;
  assign cfg_accept_s = cfg_valid & ~pending_q;

  // Next state and run-length counter
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ARM;
          cnt_d   = run_len;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ARM: begin
        if (cnt_q == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CNT_ONE;
        if ((cnt_q == CNT_ONE) || stop) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Double-buffered compare word: pending blocks acceptance, so ARM never races an overwrite
  always_comb begin
    shadow_d  = shadow_q;
    pending_d = pending_q;
    c_d       = c_q;
    if (cfg_accept_s) begin
      shadow_d  = cfg_data;
      pending_d = 1'b1;
    end else if ((state_q == ST_ARM) && pending_q) begin
      c_d       = shadow_q;
      pending_d = 1'b0;
    end else begin
      pending_d = pending_q;
    end
  end

  // Output decodes of the next state, so the registered outputs track the state flop
  always_comb begin
    p0_d   = (state_d == ST_RUN);
    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  // Control and config flops
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      c_q       <= '0;
      shadow_q  <= '0;
      pending_q <= 1'b0;
      p0_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      c_q       <= c_d;
      shadow_q  <= shadow_d;
      pending_q <= pending_d;
      p0_q      <= p0_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign C    = c_q;
  assign P_0  = p0_q;
  assign busy = busy_q;
  assign done = done_q;

`ifdef S420_DRV_HITCNT_EN
  logic [HW-1:0] hit_q, hit_d;

  // Hit counter: cleared in ARM, counts Z during RUN, sticks at all-ones
  always_comb begin
    hit_d = hit_q;
    if (state_q == ST_ARM) begin
      hit_d = '0;
    end else if ((state_q == ST_RUN) && Z && !(&hit_q)) begin
      hit_d = hit_q + HW'(1);
    end else begin
      hit_d = hit_q;
    end
  end

  // Hit counter flop
  always_ff @(posedge CK or negedge RN) begin
    if (!RN) begin
      hit_q <= '0;
    end else begin
      hit_q <= hit_d;
    end
  end

  assign hit_cnt = hit_q;
`else
  logic unused_z;
  assign unused_z = Z;
  assign hit_cnt  = '0;
`endif

endmodule
